// File: rtl/factorial_pkg.sv
// rtl/factorial_pkg.sv - shared state encoding and default sizing for the factorial controller
package factorial_pkg;

    localparam int MUL_LAT_DEF = 1;
    localparam int WAIT_W_DEF  = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHECK = 3'd2,
        S_MUL   = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_e;

endpackage

// File: rtl/factorial_ctrl_if.sv
// rtl/factorial_ctrl_if.sv - requester/datapath handshake bundle for the factorial controller
interface factorial_ctrl_if;
    logic go;
    logic cnt_gt1;
    logic mul_ovf;
    logic load_cnt;
    logic dec_cnt;
    logic load_reg;
    logic sel_init;
    logic busy;
    logic done;
    logic err;

    modport master (
        output go, cnt_gt1, mul_ovf,
        input  load_cnt, dec_cnt, load_reg, sel_init, busy, done, err
    );

    modport slave (
        input  go, cnt_gt1, mul_ovf,
        output load_cnt, dec_cnt, load_reg, sel_init, busy, done, err
    );
endinterface

// File: rtl/factorial_wait_cnt.sv
// rtl/factorial_wait_cnt.sv - loadable down-counter with zero flag for the multiplier wait
module factorial_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/factorial_ctrl.sv
// rtl/factorial_ctrl.sv - factorial control FSM with Moore strobes; FACTORIAL_OVF_CHECK_EN adds the ERR state
module factorial_ctrl
    import factorial_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int WAIT_W  = WAIT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    factorial_ctrl_if.slave   bus
);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MUL_LAT - 1);

    state_e state_q, state_d;
    logic   wait_load, wait_dec, wait_zero;

    factorial_wait_cnt #(.W(WAIT_W)) u_wait (
        .clk        (clk),
        .rst        (rst),
        .load_i     (wait_load),
        .load_val_i (WAIT_INIT),
        .dec_i      (wait_dec),
        .zero_o     (wait_zero)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        wait_load = 1'b0;
        wait_dec  = 1'b0;
        case (state_q)
            S_IDLE:  if (bus.go) state_d = S_INIT;
            S_INIT:  state_d = S_CHECK;
            S_CHECK: begin
                if (bus.cnt_gt1) begin
                    state_d   = S_MUL;
                    wait_load = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_MUL: begin
                if (wait_zero) begin
`ifdef FACTORIAL_OVF_CHECK_EN
                    state_d = bus.mul_ovf ? S_ERR : S_WB;
`else
                    state_d = S_WB;
`endif
                end else begin
                    wait_dec = 1'b1;
                end
            end
            S_WB:    state_d = S_CHECK;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.load_cnt = 1'b0;
        bus.dec_cnt  = 1'b0;
        bus.load_reg = 1'b0;
        bus.sel_init = 1'b0;
        bus.done     = 1'b0;
        bus.busy     = (state_q != S_IDLE);
        case (state_q)
            S_INIT: begin
                bus.load_cnt = 1'b1;
                bus.load_reg = 1'b1;
                bus.sel_init = 1'b1;
            end
            S_WB: begin
                bus.load_reg = 1'b1;
                bus.dec_cnt  = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

`ifdef FACTORIAL_OVF_CHECK_EN
    logic err_q, err_d;

    // Set on entry to ERR, cleared on entry to INIT so a new run starts clean.
    always_comb begin
        err_d = err_q;
        if (state_d == S_ERR)
            err_d = 1'b1;
        else if (state_d == S_INIT)
            err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    logic unused_mul_ovf;
    assign unused_mul_ovf = bus.mul_ovf;
    assign bus.err        = 1'b0;
`endif
endmodule
